// File: rtl/card_row_renderer.sv
// Renders a row of playing cards on the VGA raster with a frame-paced deal-reveal animation.
// Two-cycle pixel pipeline: address/classify in cycle N, font bit select and colour register in N+1.
module card_row_renderer #(
  parameter int NUM_CARDS     = 4,
  parameter int CARD_W        = 100,
  parameter int CARD_H        = 150,
  parameter int CARD_GAP      = 50,
  parameter int ROW_X0        = 50,
  parameter int ROW_Y0        = 170,
  parameter int RANK_SCALE    = 2,
  parameter int SUIT_SCALE    = 4,
  parameter int REVEAL_FRAMES = 30,
  localparam int REVW         = $clog2(NUM_CARDS + 1),
  localparam int FW           = $clog2(REVEAL_FRAMES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   frame_start,
  input  logic                   start_reveal,
  input  logic [4*NUM_CARDS-1:0] card_rank,
  input  logic [2*NUM_CARDS-1:0] card_suit,
  input  logic [7:0]             font_data,
  output logic [10:0]            font_address,
  output logic [3:0]             Red,
  output logic [3:0]             Green,
  output logic [3:0]             Blue,
  output logic                   reveal_done,
  output logic [1:0]             dbg_state,
  output logic [REVW-1:0]        dbg_revealed,
  output logic [FW-1:0]          dbg_fcnt
);

  localparam int RLOG = $clog2(RANK_SCALE);
  localparam int SLOG = $clog2(SUIT_SCALE);
  localparam int RBX  = 10;
  localparam int RBY  = 10;
  localparam int RBW  = 8 * RANK_SCALE;
  localparam int RBH  = 16 * RANK_SCALE;
  localparam int SBX  = (CARD_W - 8 * SUIT_SCALE) / 2;
  localparam int SBY  = (CARD_H - 16 * SUIT_SCALE) / 2;
  localparam int SBW  = 8 * SUIT_SCALE;
  localparam int SBH  = 16 * SUIT_SCALE;

  localparam logic [1:0] CLS_BG    = 2'd0;
  localparam logic [1:0] CLS_BACK  = 2'd1;
  localparam logic [1:0] CLS_FACE  = 2'd2;
  localparam logic [1:0] CLS_GLYPH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [REVW-1:0] revealed, revealed_n;
  logic [FW-1:0]   fcnt, fcnt_n;

  function automatic int card_x0(input int i);
    return ROW_X0 + i * (CARD_W + CARD_GAP);
  endfunction

  // Returns 0 for ranks that have no glyph.
  function automatic logic [6:0] rank_code(input logic [3:0] r);
    case (r)
      4'd1:    return 7'h41;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
               return 7'h30 + {3'b000, r};
      4'd10:   return 7'h54;
      4'd11:   return 7'h4A;
      4'd12:   return 7'h51;
      4'd13:   return 7'h4B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] suit_code(input logic [1:0] s);
    case (s)
      2'd0:    return 7'h06;
      2'd1:    return 7'h03;
      2'd2:    return 7'h04;
      default: return 7'h05;
    endcase
  endfunction

  // ---------------- reveal sequencer ----------------
  always_comb begin
    state_n    = state;
    revealed_n = revealed;
    fcnt_n     = fcnt;
    if (start_reveal) begin
      state_n    = REVEAL;
      revealed_n = '0;
      fcnt_n     = '0;
    end else if (state == REVEAL && frame_start) begin
      if (fcnt == FW'(REVEAL_FRAMES - 1)) begin
        fcnt_n     = '0;
        revealed_n = revealed + 1'b1;
        if (revealed_n == REVW'(NUM_CARDS)) state_n = DONE;
      end else begin
        fcnt_n = fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      revealed    <= '0;
      fcnt        <= '0;
      reveal_done <= 1'b0;
    end else begin
      state       <= state_n;
      revealed    <= revealed_n;
      fcnt        <= fcnt_n;
      reveal_done <= (state_n == DONE);
    end
  end

  assign dbg_state    = state;
  assign dbg_revealed = revealed;
  assign dbg_fcnt     = fcnt;

  // ---------------- pixel stage 0: locate card ----------------
  logic       hit, face_up;
  logic [3:0] rank;
  logic [1:0] suit;
  int         dx, dy;

  always_comb begin
    hit     = 1'b0;
    face_up = 1'b0;
    rank    = '0;
    suit    = '0;
    dx      = 0;
    dy      = 0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (int'(DrawX) >= card_x0(i) && int'(DrawX) < card_x0(i) + CARD_W &&
          int'(DrawY) >= ROW_Y0 && int'(DrawY) < ROW_Y0 + CARD_H) begin
        hit     = 1'b1;
        face_up = (i < int'(revealed));
        rank    = card_rank[4*i +: 4];
        suit    = card_suit[2*i +: 2];
        dx      = int'(DrawX) - card_x0(i);
        dy      = int'(DrawY) - ROW_Y0;
      end
    end
  end

  // ---------------- pixel stage 0: glyph box and font address ----------------
  logic       in_rank, in_suit, glyph, is_red;
  logic [6:0] code;
  logic [3:0] row;
  logic [2:0] col;
  logic [1:0] cls;

  always_comb begin
    in_rank = hit && face_up && (rank_code(rank) != 7'h00) &&
              dx >= RBX && dx < RBX + RBW && dy >= RBY && dy < RBY + RBH;
    in_suit = hit && face_up &&
              dx >= SBX && dx < SBX + SBW && dy >= SBY && dy < SBY + SBH;
    glyph   = in_rank || in_suit;
    is_red  = (suit == 2'd1) || (suit == 2'd2);
    code    = '0;
    row     = '0;
    col     = '0;
    if (in_rank) begin
      code = rank_code(rank);
      row  = 4'((dy - RBY) >> RLOG);
      col  = 3'((dx - RBX) >> RLOG);
    end else if (in_suit) begin
      code = suit_code(suit);
      row  = 4'((dy - SBY) >> SLOG);
      col  = 3'((dx - SBX) >> SLOG);
    end
    font_address = glyph ? {code, row} : 11'h000;
    cls = CLS_BG;
    if (hit) cls = !face_up ? CLS_BACK : (glyph ? CLS_GLYPH : CLS_FACE);
  end

  // ---------------- stage 1 registers ----------------
  // s1_valid keeps the colour output black until the first real pixel has crossed the pipeline.
  logic       s1_valid, s1_red;
  logic [1:0] s1_cls;
  logic [2:0] s1_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_BG;
      s1_bit   <= '0;
      s1_red   <= 1'b0;
    end else begin
      s1_valid <= 1'b1;
      s1_cls   <= cls;
      s1_bit   <= 3'd7 - col;
      s1_red   <= is_red;
    end
  end

  // ---------------- stage 2: colour ----------------
  logic [11:0] rgb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= 12'h000;
    end else if (!s1_valid) begin
      rgb <= 12'h000;
    end else begin
      case (s1_cls)
        CLS_GLYPH: rgb <= font_data[s1_bit] ? (s1_red ? 12'hF00 : 12'h000) : 12'hFFF;
        CLS_FACE:  rgb <= 12'hFFF;
        CLS_BACK:  rgb <= 12'h22A;
        default:   rgb <= 12'h362;
      endcase
    end
  end

  assign Red   = rgb[11:8];
  assign Green = rgb[7:4];
  assign Blue  = rgb[3:0];

endmodule

// File: tb/tb_card_row_renderer.sv
// Bench for card_row_renderer: directed reveal sequence plus a random back-to-back pixel sweep.
module tb_card_row_renderer;

  logic        clk;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        frame_start, start_reveal;
  logic [15:0] card_rank;
  logic [7:0]  card_suit;
  logic [7:0]  font_data;
  logic [10:0] font_address;
  logic [3:0]  Red, Green, Blue;
  logic        reveal_done;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_revealed;
  logic [4:0]  dbg_fcnt;

  card_row_renderer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .frame_start  (frame_start),
    .start_reveal (start_reveal),
    .card_rank    (card_rank),
    .card_suit    (card_suit),
    .font_data    (font_data),
    .font_address (font_address),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .reveal_done  (reveal_done),
    .dbg_state    (dbg_state),
    .dbg_revealed (dbg_revealed),
    .dbg_fcnt     (dbg_fcnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        cur_tag = 1'b0;
  logic        h1 = 1'b0;
  logic        h2 = 1'b0;
  logic [7:0]  fd_next = 8'h00;

  // ---------------- scoreboard: colour shows two cycles after the pixel ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (h2) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rgb_underflow got=%h required=an expected entry", {Red, Green, Blue});
      end else begin
        e = exp_q.pop_front();
        if ({Red, Green, Blue} !== e[11:0]) begin
          failures++;
          $display("FAIL rgb pixel=(%0d,%0d) got=%h required=%h", e[31:22], e[21:12], {Red, Green, Blue}, e[11:0]);
        end
      end
    end
    h2 = h1;
    h1 = cur_tag;
  end

  // ---------------- reference model ----------------
  function automatic int ref_rank_code(input logic [3:0] r);
    case (r)
      4'd1:    return 65;
      4'd10:   return 84;
      4'd11:   return 74;
      4'd12:   return 81;
      4'd13:   return 75;
      default: return (r >= 4'd2 && r <= 4'd9) ? 48 + int'(r) : -1;
    endcase
  endfunction

  function automatic void model(input int x, input int y, input logic [7:0] fd, input int rev,
                                input logic [15:0] rk, input logic [7:0] su,
                                output logic [10:0] addr, output logic [11:0] rgb);
    int code, row, col, ddx, ddy;
    logic [3:0] r;
    logic [1:0] s;
    addr = 11'h000;
    rgb  = 12'h362;
    row  = 0;
    col  = 0;
    for (int c = 0; c < 4; c++) begin
      ddx = x - (50 + 150 * c);
      ddy = y - 170;
      if (ddx >= 0 && ddx < 100 && ddy >= 0 && ddy < 150) begin
        if (c >= rev) rgb = 12'h22A;
        else begin
          r = rk[4*c +: 4];
          s = su[2*c +: 2];
          rgb = 12'hFFF;
          code = -1;
          if (ddx >= 10 && ddx < 26 && ddy >= 10 && ddy < 42 && ref_rank_code(r) >= 0) begin
            code = ref_rank_code(r); row = (ddy - 10) / 2; col = (ddx - 10) / 2;
          end else if (ddx >= 34 && ddx < 66 && ddy >= 43 && ddy < 107) begin
            code = (s == 2'd0) ? 6 : (s == 2'd1) ? 3 : (s == 2'd2) ? 4 : 5;
            row = (ddy - 43) / 4; col = (ddx - 34) / 4;
          end
          if (code >= 0) begin
            addr = 11'(code * 16 + row);
            if (fd[7 - col]) rgb = (s == 2'd1 || s == 2'd2) ? 12'hF00 : 12'h000;
          end
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pix(input int x, input int y, input logic [7:0] fd,
                     input logic [10:0] exp_addr, input logic [11:0] exp_rgb, input string name);
    DrawX     = 10'(x);
    DrawY     = 10'(y);
    font_data = fd_next;
    fd_next   = fd;
    cur_tag   = 1'b1;
    exp_q.push_back({10'(x), 10'(y), exp_rgb});
    #1;
    checks++;
    if (font_address !== exp_addr) begin
      failures++;
      $display("FAIL addr_%s pixel=(%0d,%0d) got=%h required=%h", name, x, y, font_address, exp_addr);
    end
    @(posedge clk); #1;
    cur_tag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      font_data = fd_next;
      fd_next   = 8'h00;
      cur_tag   = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      idle(1);
      frame_start = 1'b0;
      idle(1);
    end
  endtask

  task automatic kick();
    start_reveal = 1'b1;
    idle(1);
    start_reveal = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++;
    if ({Red, Green, Blue} !== 12'h000 || reveal_done !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold got rgb=%h done=%b state=%0d required rgb=000 done=0 state=0",
               {Red, Green, Blue}, reveal_done, dbg_state);
    end
    reset_n = 1'b1;
    idle(2);
    checks++;
    if ({Red, Green, Blue} !== 12'h362) begin
      failures++;
      $display("FAIL reset_release_bg got=%h required=362", {Red, Green, Blue});
    end
  endtask

  task automatic test_idle();
    pix(100, 200, 8'hFF, 11'h000, 12'h22A, "idle_back");
    pix(0,   0,   8'hFF, 11'h000, 12'h362, "idle_bg");
    pix(50,  170, 8'h00, 11'h000, 12'h22A, "edge_lo");
    pix(49,  170, 8'h00, 11'h000, 12'h362, "edge_left");
    pix(150, 170, 8'h00, 11'h000, 12'h362, "edge_right");
    pix(149, 319, 8'h00, 11'h000, 12'h22A, "edge_corner");
    pix(149, 320, 8'h00, 11'h000, 12'h362, "edge_bottom");
    idle(3);
    checks++;
    if (reveal_done !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL idle_state got done=%b state=%0d required done=0 state=0", reveal_done, dbg_state);
    end
  endtask

  task automatic test_first_reveal();
    kick();
    frames(29);
    pix(60, 180, 8'h80, 11'h000, 12'h22A, "before_reveal");
    frames(1);
    pix(60, 180, 8'h80, 11'h410, 12'h000, "rank_set");
    pix(60, 180, 8'h00, 11'h410, 12'hFFF, "rank_clear");
    pix(62, 180, 8'h40, 11'h410, 12'h000, "rank_col1");
    pix(61, 180, 8'h40, 11'h410, 12'hFFF, "rank_col0");
    pix(60, 183, 8'h00, 11'h411, 12'hFFF, "rank_row1");
    pix(234, 213, 8'hFF, 11'h000, 12'h22A, "card1_down");
    idle(3);
    checks++;
    if (dbg_revealed !== 3'd1) begin
      failures++;
      $display("FAIL revealed_after_30 got=%0d required=1", dbg_revealed);
    end
  endtask

  task automatic test_suit();
    frames(30);
    pix(234, 213, 8'hFF, 11'h030, 12'hF00, "heart_tl");
    pix(266, 213, 8'hFF, 11'h000, 12'hFFF, "heart_right_out");
    pix(265, 276, 8'h01, 11'h03F, 12'hF00, "heart_br");
    pix(265, 277, 8'h01, 11'h000, 12'hFFF, "heart_below");
    idle(3);
  endtask

  task automatic test_reveal_done();
    frames(59);
    checks++;
    if (reveal_done !== 1'b0 || dbg_revealed !== 3'd3) begin
      failures++;
      $display("FAIL pre_done got done=%b revealed=%0d required done=0 revealed=3", reveal_done, dbg_revealed);
    end
    frame_start = 1'b1;
    #1;
    checks++;
    if (reveal_done !== 1'b0) begin
      failures++;
      $display("FAIL done_early got=%b required=0", reveal_done);
    end
    idle(1);
    frame_start = 1'b0;
    checks++;
    if (reveal_done !== 1'b1 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL done_rise got done=%b state=%0d required done=1 state=2", reveal_done, dbg_state);
    end
    frames(5);
    checks++;
    if (reveal_done !== 1'b1 || dbg_revealed !== 3'd4) begin
      failures++;
      $display("FAIL done_hold got done=%b revealed=%0d required done=1 revealed=4", reveal_done, dbg_revealed);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] a;
    logic [11:0] c;
    logic [7:0]  fd;
    int          x, y, k;
    for (int i = 0; i < 200; i++) begin
      card_rank = 16'($urandom);
      card_suit = 8'($urandom);
      fd = 8'($urandom);
      k = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       begin x = 50 + 150 * k + $urandom_range(8, 28);  y = $urandom_range(178, 214); end
        1:       begin x = 50 + 150 * k + $urandom_range(32, 68); y = $urandom_range(211, 279); end
        default: begin x = $urandom_range(0, 639);                y = $urandom_range(160, 330); end
      endcase
      model(x, y, fd, 4, card_rank, card_suit, a, c);
      pix(x, y, fd, a, c, "random");
    end
    idle(3);
    card_rank = {4'd13, 4'd12, 4'd5, 4'd1};
    card_suit = {2'd3, 2'd2, 2'd1, 2'd0};
  endtask

  task automatic test_restart();
    start_reveal = 1'b1;
    #1;
    checks++;
    if (reveal_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_same_cycle got=%b required=1", reveal_done);
    end
    idle(1);
    start_reveal = 1'b0;
    checks++;
    if (reveal_done !== 1'b0 || dbg_state !== 2'd1 || dbg_revealed !== 3'd0) begin
      failures++;
      $display("FAIL restart got done=%b state=%0d revealed=%0d required done=0 state=1 revealed=0",
               reveal_done, dbg_state, dbg_revealed);
    end
    pix(100, 200, 8'hFF, 11'h000, 12'h22A, "restart_card0");
    pix(550, 250, 8'hFF, 11'h000, 12'h22A, "restart_card3");
    idle(3);
  endtask

  task automatic test_collision();
    frames(35);
    checks++;
    if (dbg_revealed !== 3'd1 || dbg_fcnt !== 5'd5) begin
      failures++;
      $display("FAIL pre_collision got revealed=%0d fcnt=%0d required revealed=1 fcnt=5", dbg_revealed, dbg_fcnt);
    end
    start_reveal = 1'b1;
    frame_start  = 1'b1;
    idle(1);
    start_reveal = 1'b0;
    frame_start  = 1'b0;
    checks++;
    if (dbg_revealed !== 3'd0 || dbg_fcnt !== 5'd0 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL collision got revealed=%0d fcnt=%0d state=%0d required 0 0 1", dbg_revealed, dbg_fcnt, dbg_state);
    end
    frames(1);
    checks++;
    if (dbg_fcnt !== 5'd1) begin
      failures++;
      $display("FAIL fcnt_after_collision got=%0d required=1", dbg_fcnt);
    end
  endtask

  task automatic test_rank0();
    card_rank[3:0] = 4'd0;
    frames(29);
    pix(60,  180, 8'hFF, 11'h000, 12'hFFF, "rank0_box");
    pix(84,  213, 8'h80, 11'h060, 12'h000, "rank0_spade");
    pix(234, 213, 8'hFF, 11'h000, 12'h22A, "rank0_card1_down");
    idle(3);
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    #1;
    checks++;
    if (dbg_state !== 2'd0 || dbg_revealed !== 3'd0 || {Red, Green, Blue} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid got state=%0d revealed=%0d rgb=%h required 0 0 000",
               dbg_state, dbg_revealed, {Red, Green, Blue});
    end
    idle(2);
    reset_n = 1'b1;
    idle(2);
  endtask

  initial begin
    reset_n      = 1'b0;
    DrawX        = '0;
    DrawY        = '0;
    frame_start  = 1'b0;
    start_reveal = 1'b0;
    font_data    = 8'h00;
    card_rank    = {4'd13, 4'd12, 4'd5, 4'd1};
    card_suit    = {2'd3, 2'd2, 2'd1, 2'd0};
    @(posedge clk); #1;
    test_reset();
    test_idle();
    test_first_reveal();
    test_suit();
    test_reveal_done();
    test_back_to_back();
    test_restart();
    test_collision();
    test_rank0();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_row_renderer.md
# card_row_renderer

Parametrised renderer for a row of playing cards on the 640x480 VGA raster, with an animated deal-reveal sequence. Sits between the VGA controller (DrawX/DrawY, frame pulse), the shared synchronous 8x16 font ROM and the colour mux. Per-card rank and suit come from game logic. Cards start face-down and turn face-up one at a time, each after a programmable number of frames. Font fetch and colour generation are pipelined to match the ROM's one-cycle read latency.

## Interface
- NUM_CARDS, 4, number of cards in the row (1-8)
- CARD_W, 100, card width in pixels
- CARD_H, 150, card height in pixels
- CARD_GAP, 50, horizontal gap between cards
- ROW_X0, 50, left edge of card 0
- ROW_Y0, 170, top edge of the row
- RANK_SCALE, 2, rank glyph magnification (power of two: 1, 2, 4)
- SUIT_SCALE, 4, suit glyph magnification (power of two: 1, 2, 4)
- REVEAL_FRAMES, 30, frames between successive card reveals (>=1)

- clk  in  1  pixel clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- frame_start  in  1  one-cycle pulse once per frame, in vertical blank
- start_reveal  in  1  one-cycle pulse; restarts the reveal sequence
- card_rank  in  4*NUM_CARDS  rank of card i in bits [4i+3:4i]
- card_suit  in  2*NUM_CARDS  suit of card i in bits [2i+1:2i]
- font_data  in  8  font ROM row, valid one cycle after font_address; MSB is the leftmost pixel
- font_address  out  11  font ROM address, {char, row}
- Red, Green, Blue  out  4 each  pixel colour
- reveal_done  out  1  high while every card is face-up

## Operation
- Card i occupies X0_i <= DrawX < X0_i+CARD_W and ROW_Y0 <= DrawY < ROW_Y0+CARD_H, where X0_i = ROW_X0 + i*(CARD_W+CARD_GAP). Bounds are inclusive-low and exclusive-high. Cards do not overlap.
- Rank glyph:
  - Box origin: card offset (10,10). Box size: 8*RANK_SCALE x 16*RANK_SCALE.
  - Code mapping: 1→0x41 'A'; 2-9→0x32-0x39; 10→0x54 'T'; 11→0x4A 'J'; 12→0x51 'Q'; 13→0x4B 'K'.
  - Ranks 0, 14 and 15 draw no rank glyph.
- Suit glyph:
  - Box origin: card offset ((CARD_W-8*SUIT_SCALE)/2, (CARD_H-16*SUIT_SCALE)/2). With default parameters the offset is (34,43).
  - Suit mapping: 0 spade 0x06 (black); 1 heart 0x03 (red); 2 diamond 0x04 (red); 3 club 0x05 (black).
- Glyph addressing:
  - font_address = code*16 + ((DrawY-boxY) >> log2(scale)).
  - Bit index = 7 - ((DrawX-boxX) >> log2(scale)).
  - Scale division is by shift only; no dividers.
  - Outside every glyph box, or on a face-down card, font_address = 0.
- Colour priority:
  1. Glyph pixel set on a face-up card: red F,0,0 or black 0,0,0, according to suit.
  2. Face-up card: white F,F,F.
  3. Face-down card: back colour 2,2,A. No glyphs are drawn.
  4. Otherwise: background 3,6,2.
- Reveal FSM, states IDLE / REVEAL / DONE. revealed is a count of width clog2(NUM_CARDS+1); fcnt is the frame counter.
  - IDLE: revealed=0, all cards face-down.
  - Any state + start_reveal: state→REVEAL, revealed←0, fcnt←0. start_reveal has priority over a coincident frame_start.
  - REVEAL + frame_start:
    - If fcnt==REVEAL_FRAMES-1: fcnt←0, revealed←revealed+1.
    - Else: fcnt←fcnt+1.
  - When revealed reaches NUM_CARDS, state→DONE in the same update.
  - DONE: holds; frame_start is ignored.
- Card i is face-up iff i < revealed. Because revealed changes only on frame_start, a card never changes face mid-frame.
- card_rank and card_suit are sampled every pixel and are not latched. Changing them mid-frame takes effect at the corresponding pixel.

## Timing
- Pixel pipeline, for DrawX/DrawY presented in cycle N:
  - font_address is combinational in cycle N.
  - Stage-1 registers capture region class, glyph bit index and colour class at the end of cycle N.
  - font_data arrives in cycle N+1.
  - Red/Green/Blue are registered and show pixel N in cycle N+2.
- Total latency: 2 cycles, constant for every pixel and region.
- reveal_done is registered and equals (state==DONE). It is set in the cycle after the frame_start that completes the last reveal. It is cleared in the cycle after start_reveal.
- Reset values: state IDLE, revealed 0, fcnt 0, pipeline registers cleared, Red/Green/Blue 0,0,0, reveal_done 0. Asserting reset mid-sequence returns immediately to IDLE.

## Test plan
- Reset release, pixel (0,0) held -> Red/Green/Blue 0,0,0 during reset; 3,6,2 from 2 cycles after release.
- IDLE, pixel (100,200) -> font_address 0x000; colour 2,2,A two cycles later; reveal_done 0.
- start_reveal, then 30 frame_start pulses, card0 rank 1 suit 0, pixel (60,180), font_data 0x80 -> font_address 0x410; colour 0,0,0 at N+2. The same pixel with font_data 0x00 gives F,F,F.
- Card1 heart face-up, pixel (234,213), font_data 0xFF -> font_address 0x030; colour F,0,0 at N+2. Pixel (266,213) -> font_address 0x000; colour F,F,F.
- NUM_CARDS=4, REVEAL_FRAMES=30: reveal_done rises exactly one cycle after the 120th frame_start and stays high; a further start_reveal drops it next cycle and all cards return to face-down.
- Mid-REVEAL, start_reveal and frame_start in the same cycle -> revealed 0 and fcnt 0 next cycle. Rank 0 card face-up -> no rank glyph drawn, card pixel F,F,F.
